buf_sobel_to_threshold: RTL and testbench
=========================================

Name: buf_sobel_to_threshold

Overview:
- Streaming 3x3 window generator (line buffer) between the Sobel stage and the non-max-suppression/threshold stage.
- Accepts one raster-order pixel per cycle while `write` is high.
- Presents the 3x3 neighbourhood on out0..out8 and pulses `ready` for every window lying fully inside the image, giving (WIDTH-2)*(HEIGHT-2) windows per frame.
- The same block also buffers gradient direction; consumers may use only out4 and truncate its width.

Parameters:
- WIDTH, 506, pixels per row (>=3).
- HEIGHT, 506, rows per frame (>=3).
- R_KERNEL, 1, kernel radius; only 1 is supported (3x3 window).
- DATA_W, 11, bits per pixel.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- write, in, 1, serial_in holds a valid pixel this cycle.
- serial_in, in, DATA_W, pixel in raster order (row-major, left to right).
- out0..out8, out, DATA_W each, window row-major: out0/out1/out2 top row (left/centre/right), out3/out4/out5 middle row, out6/out7/out8 bottom row; out4 is the centre pixel.
- ready, out, 1, out0..out8 hold a new valid interior window this cycle.

Behaviour:
- Reset value of every output: out0..out8 = 0 and ready = 0.
- Reset value of internal state: col = 0, row = 0, window registers = 0.
- Line buffer memories are not reset. They are overwritten before use, because ready is suppressed for rows 0 and 1.
- Storage: two line buffers lb0 (previous row) and lb1 (row before that), each WIDTH x DATA_W, indexed by col. Window: 3x3 register array.
- On a rising edge with write=1, pixel p at position (row, col):
  - Window shifts left one column.
  - New right column is top = lb1[col], middle = lb0[col], bottom = p.
  - lb1[col] <= lb0[col]; lb0[col] <= p.
  - ready <= (row >= 2) && (col >= 2).
- Counter advance on each write: col increments. At col = WIDTH-1, col wraps to 0 and row increments. At row = HEIGHT-1 with col = WIDTH-1, row also wraps to 0, so the next frame starts with no extra control.
- Latency: the window whose bottom-right pixel is p appears on the outputs one cycle after p is written, with ready=1. Its centre is pixel (row-1, col-1).
- On a rising edge with write=0:
  - Counters, window and line buffers hold.
  - ready <= 0.
  - out0..out8 keep their last values.
- Gaps in `write` are allowed anywhere, mid-row or between frames. Position is tracked only by the count of accepted pixels.
- Windows never straddle a row edge: the columns left over from the previous row sit in the window at col 0/1, but ready stays low there.
- Frame boundary: the first ready of each frame occurs on the cycle after pixel (2,2) is written.
- Exactly (WIDTH-2)*(HEIGHT-2) ready pulses per frame.
- Asynchronous reset mid-frame: the block immediately returns to its reset state. The next accepted pixel is treated as (0,0) and the first ready comes after pixel (2,2) of the new frame.
- There is no back-pressure. Downstream must accept each ready pulse on the cycle it is asserted.

Decomposition:
- Shared package: DATA_W and the default image dimensions (WIDTH, HEIGHT, R_KERNEL).
- One natural sub-module: line_buffer_ram, a single-port WIDTH x DATA_W RAM with synchronous write and read-before-write at the same address. Instantiate it twice, or once with 2*DATA_W width.
- Counters, window registers and the ready logic stay in the top level.

Test Plan:
- Ramp frame: WIDTH=8, HEIGHT=6, pixel = row*16+col, write held high throughout.
  - -> First ready comes one cycle after pixel (2,2), with out0..out8 = 0x00, 0x01, 0x02, 0x10, 0x11, 0x12, 0x20, 0x21, 0x22.
  - -> 24 ready pulses in total.
  - -> Last window centre out4 = 0x46.
- Row edge: same stimulus.
  - -> No ready after pixels (3,0) or (3,1).
  - -> After pixel (3,2): out0 = 0x10, out8 = 0x32.
- Write gaps: deassert write for 3 cycles after pixel (2,4).
  - -> ready = 0 and outputs frozen at the (2,4) window during the gap.
  - -> After pixel (2,5), the window is out0 = 0x03 .. out8 = 0x25, identical to the gap-free run.
- Reset: assert rst mid-row (3,3).
  - -> All outputs 0 and ready 0 immediately.
  - -> Restarting the ramp gives the first ready after the new pixel (2,2), with out4 = 0x11.
- Back-to-back frames: two ramp frames with a second frame offset of 0x80.
  - -> The second frame yields 24 pulses.
  - -> First window of the second frame is out0 = 0x80 .. out8 = 0xA2, with no first-frame data.
- Max value: all pixels 0x7FF.
  - -> Every out = 0x7FF with no overflow or sign effects.
  - -> A consumer using only the low 2 bits of out4 reads 2'b11.

Source files
------------

// File: rtl/buf_sobel_to_threshold_pkg.sv
// Shared constants and helpers for the Sobel-to-threshold 3x3 window buffer.
// Default frame geometry and pixel width live here so every stage agrees on them.
package buf_sobel_to_threshold_pkg;

    localparam int unsigned DEF_WIDTH    = 506;
    localparam int unsigned DEF_HEIGHT   = 506;
    localparam int unsigned DEF_R_KERNEL = 1;
    localparam int unsigned DEF_DATA_W   = 11;

    localparam int unsigned WIN_TAPS = 9;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned ctr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned frame_windows(input int unsigned w, input int unsigned h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/buf_sobel_to_threshold_line_buffer_ram.sv
// Single-port row buffer: synchronous write, combinational read, so a write
// and a read at the same address in one cycle return the previous contents.
module line_buffer_ram
    import buf_sobel_to_threshold_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_WIDTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = ctr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are never reset; every location is rewritten before it is consumed.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/buf_sobel_to_threshold.sv
// Streaming 3x3 window generator between the Sobel and threshold stages.
// One raster pixel per write; ready flags each window that lies fully inside the frame.
module buf_sobel_to_threshold
    import buf_sobel_to_threshold_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned HEIGHT   = DEF_HEIGHT,
    parameter int unsigned R_KERNEL = DEF_R_KERNEL,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] serial_in,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [DATA_W-1:0] out8,
    output logic              ready
);

    localparam int unsigned COL_W = ctr_w(WIDTH);
    localparam int unsigned ROW_W = ctr_w(HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2 * R_KERNEL);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2 * R_KERNEL);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] win_q [WIN_TAPS];
    logic [DATA_W-1:0] win_d [WIN_TAPS];
    logic              ready_q, ready_d;

    logic [2*DATA_W-1:0] lb_rdata;
    logic [2*DATA_W-1:0] lb_wdata;
    logic [DATA_W-1:0]   lb1_rd;
    logic [DATA_W-1:0]   lb0_rd;

    // Both row buffers share one RAM word: upper half is two rows back, lower half the previous row.
    assign lb1_rd   = lb_rdata[2*DATA_W-1:DATA_W];
    assign lb0_rd   = lb_rdata[DATA_W-1:0];
    assign lb_wdata = {lb0_rd, serial_in};

    line_buffer_ram #(
        .DEPTH  (WIDTH),
        .DATA_W (2 * DATA_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk_i   (clk),
        .we_i    (write),
        .addr_i  (col_q),
        .wdata_i (lb_wdata),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (write) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (write) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = serial_in;
        end
    end

    // Columns 0/1 still hold the tail of the previous row, so they never qualify.
    always_comb begin
        ready_d = write && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            ready_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            ready_q <= ready_d;
        end
    end

    assign out0  = win_q[0];
    assign out1  = win_q[1];
    assign out2  = win_q[2];
    assign out3  = win_q[3];
    assign out4  = win_q[4];
    assign out5  = win_q[5];
    assign out6  = win_q[6];
    assign out7  = win_q[7];
    assign out8  = win_q[8];
    assign ready = ready_q;

endmodule

// File: tb/tb_buf_sobel_to_threshold.sv
// Directed bench for buf_sobel_to_threshold on an 8x6 frame with ramp pixels row*16+col.
module tb_buf_sobel_to_threshold;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          write;
    logic [DW-1:0] serial_in;
    logic [DW-1:0] out0, out1, out2, out3, out4, out5, out6, out7, out8;
    logic          ready;
    logic [DW-1:0] ow [9];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buf_sobel_to_threshold #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .R_KERNEL (1),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .serial_in (serial_in),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .ready     (ready)
    );

    always_comb begin
        ow[0] = out0; ow[1] = out1; ow[2] = out2;
        ow[3] = out3; ow[4] = out4; ow[5] = out5;
        ow[6] = out6; ow[7] = out7; ow[8] = out8;
    end

    function automatic logic [DW-1:0] ramp(input int r, input int c, input int off);
        return DW'(off + r * 16 + c);
    endfunction

    // Drive one pixel, then return #1 after the capturing edge.
    task automatic push(input logic [DW-1:0] p);
        write     = 1'b1;
        serial_in = p;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic idle();
        write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        write = 1'b0;
        serial_in = '0;
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        for (int k = 0; k < 9; k++) if (ow[k] !== '0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_outs: out0=%h out4=%h out8=%h required all 0", out0, out4, out8);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b required 0", ready);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_ramp_frame();
        int pulses = 0;
        int bad;
        logic exp_rdy;
        logic [DW-1:0] first_win [9];
        first_win = '{11'h00, 11'h01, 11'h02, 11'h10, 11'h11, 11'h12, 11'h20, 11'h21, 11'h22};
        do_reset();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(ramp(r, c, 0));
                exp_rdy = (r >= 2) && (c >= 2);
                checks++;
                if (ready !== exp_rdy) begin
                    failures++;
                    $display("FAIL ramp_ready(%0d,%0d): got %b required %b", r, c, ready, exp_rdy);
                end
                if (ready === 1'b1) pulses++;
                if (exp_rdy) begin
                    bad = 0;
                    for (int k = 0; k < 9; k++)
                        if (ow[k] !== ramp(r - 2 + k / 3, c - 2 + k % 3, 0)) bad++;
                    checks++;
                    if (bad != 0) begin
                        failures++;
                        $display("FAIL ramp_window(%0d,%0d): out0=%h out4=%h out8=%h required %h %h %h",
                                 r, c, out0, out4, out8, ramp(r - 2, c - 2, 0), ramp(r - 1, c - 1, 0), ramp(r, c, 0));
                    end
                end
                if (r == 2 && c == 2) begin
                    bad = 0;
                    for (int k = 0; k < 9; k++) if (ow[k] !== first_win[k]) bad++;
                    checks++;
                    if (bad != 0) begin
                        failures++;
                        $display("FAIL first_window: out0=%h out4=%h out8=%h required 000 011 022", out0, out4, out8);
                    end
                end
                if (r == 3 && c == 2) begin
                    checks++;
                    if (out0 !== 11'h10 || out8 !== 11'h32) begin
                        failures++;
                        $display("FAIL row_edge_32: out0=%h out8=%h required 010 032", out0, out8);
                    end
                end
                if (r == H - 1 && c == W - 1) begin
                    checks++;
                    if (out4 !== 11'h46) begin
                        failures++;
                        $display("FAIL last_centre: out4=%h required 046", out4);
                    end
                end
            end
        end
        checks++;
        if (pulses != 24) begin
            failures++;
            $display("FAIL ramp_pulses: got %0d required 24", pulses);
        end
        idle();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_frame: ready=%b required 0", ready);
        end
    endtask

    task automatic test_write_gaps();
        do_reset();
        for (int i = 0; i < 2 * W + 5; i++) push(ramp(i / W, i % W, 0));
        checks++;
        if (ready !== 1'b1 || out0 !== 11'h02 || out4 !== 11'h13 || out8 !== 11'h24) begin
            failures++;
            $display("FAIL gap_pre: ready=%b out0=%h out4=%h out8=%h required 1 002 013 024", ready, out0, out4, out8);
        end
        for (int g = 0; g < 3; g++) begin
            idle();
            checks++;
            if (ready !== 1'b0 || out0 !== 11'h02 || out4 !== 11'h13 || out8 !== 11'h24) begin
                failures++;
                $display("FAIL gap_hold%0d: ready=%b out0=%h out4=%h out8=%h required 0 002 013 024",
                         g, ready, out0, out4, out8);
            end
        end
        push(ramp(2, 5, 0));
        checks++;
        if (ready !== 1'b1 || out0 !== 11'h03 || out4 !== 11'h14 || out8 !== 11'h25) begin
            failures++;
            $display("FAIL gap_resume: ready=%b out0=%h out4=%h out8=%h required 1 003 014 025", ready, out0, out4, out8);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        do_reset();
        for (int i = 0; i <= 3 * W + 3; i++) push(ramp(i / W, i % W, 0));
        checks++;
        if (ready !== 1'b1 || out4 !== 11'h22) begin
            failures++;
            $display("FAIL pre_reset: ready=%b out4=%h required 1 022", ready, out4);
        end
        #2;
        rst = 1'b1;
        #1;
        bad = 0;
        for (int k = 0; k < 9; k++) if (ow[k] !== '0) bad++;
        checks++;
        if (bad != 0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: ready=%b out0=%h out4=%h out8=%h required 0 000 000 000", ready, out0, out4, out8);
        end
        rst = 1'b0;
        for (int i = 0; i <= 2 * W + 2; i++) begin
            push(ramp(i / W, i % W, 0));
            if (i < 2 * W + 2) begin
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL restart_early_ready(%0d,%0d): got %b required 0", i / W, i % W, ready);
                end
            end
        end
        checks++;
        if (ready !== 1'b1 || out4 !== 11'h11) begin
            failures++;
            $display("FAIL restart_first: ready=%b out4=%h required 1 011", ready, out4);
        end
    endtask

    task automatic test_back_to_back();
        int pulses [2] = '{0, 0};
        int bad;
        logic [DW-1:0] win2 [9];
        win2 = '{11'h80, 11'h81, 11'h82, 11'h90, 11'h91, 11'h92, 11'hA0, 11'hA1, 11'hA2};
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    push(ramp(r, c, f * 128));
                    if (ready === 1'b1) pulses[f]++;
                    if (f == 1 && r == 2 && c == 2) begin
                        bad = 0;
                        for (int k = 0; k < 9; k++) if (ow[k] !== win2[k]) bad++;
                        checks++;
                        if (bad != 0 || ready !== 1'b1) begin
                            failures++;
                            $display("FAIL frame2_first: ready=%b out0=%h out4=%h out8=%h required 1 080 091 0a2",
                                     ready, out0, out4, out8);
                        end
                    end
                end
            end
        end
        checks++;
        if (pulses[0] != 24) begin
            failures++;
            $display("FAIL frame1_pulses: got %0d required 24", pulses[0]);
        end
        checks++;
        if (pulses[1] != 24) begin
            failures++;
            $display("FAIL frame2_pulses: got %0d required 24", pulses[1]);
        end
    endtask

    task automatic test_max_value();
        int pulses = 0;
        int bad = 0;
        logic [1:0] lo;
        do_reset();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(11'h7FF);
                if (ready === 1'b1) begin
                    pulses++;
                    for (int k = 0; k < 9; k++) if (ow[k] !== 11'h7FF) bad++;
                end
                if (r == 2 && c == 2) begin
                    lo = out4[1:0];
                    checks++;
                    if (lo !== 2'b11) begin
                        failures++;
                        $display("FAIL max_low_bits: got %b required 11", lo);
                    end
                end
            end
        end
        checks++;
        if (bad != 0 || pulses != 24) begin
            failures++;
            $display("FAIL max_windows: bad_taps=%0d pulses=%0d required 0 24", bad, pulses);
        end
    endtask

    initial begin
        write     = 1'b0;
        serial_in = '0;
        rst       = 1'b1;
        test_reset();
        test_ramp_frame();
        test_write_gaps();
        test_reset_midframe();
        test_back_to_back();
        test_max_value();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
